shift_pipe_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one DEPTH-stage, 1-bit shift pipeline among NREQ requesters.
- Each cycle it grants at most one requester and launches that requester's data bit into stage 1, together with a valid flag and a requester ID.
- After DEPTH cycles the bit emerges on q, tagged with out_valid and out_id, so downstream logic can route the result back to the right requester.
- Supports a global stall that freezes the pipeline and suppresses grants.

---
 rtl/shift_pipe_arbiter.sv | 98 +++++++++
 tb/tb_shift_pipe_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_arbiter.sv
// Round-robin arbiter feeding a shared DEPTH-stage 1-bit shift pipeline tagged with valid/ID.
// Optional macro SHIFT_PIPE_ARBITER_STATS_EN adds a saturating grant counter output.
module shift_pipe_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  input  logic            stall,
  output logic [NREQ-1:0] gnt,
  output logic            q,
  output logic            out_valid,
  output logic [IDW-1:0]  out_id,
  output logic            busy
`ifdef SHIFT_PIPE_ARBITER_STATS_EN
  ,
  output logic [15:0]     grant_cnt
`endif
);

  logic [IDW-1:0]   r_rr_ptr;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_dat;
  logic [IDW-1:0]   r_id [DEPTH];

  logic [NREQ-1:0]  w_gnt;
  logic             w_any;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_scan_idx;
  logic [IDW-1:0]   w_ptr_nxt;

  // Search upward from the pointer with wrap; the first hit wins, so the grant is one-hot.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_gnt      = '0;
    w_any      = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        w_scan_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
        if (!w_any && req[w_scan_idx]) begin
          w_any             = 1'b1;
          w_gnt[w_scan_idx] = 1'b1;
          w_gnt_idx         = w_scan_idx;
        end
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign gnt       = w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      r_dat    <= '0;
      // NOTE: the stage ID array is reset too, since out_id must read 0 out of reset.
      for (int s = 0; s < DEPTH; s++) r_id[s] <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      if (w_any) r_rr_ptr <= w_ptr_nxt;
      r_vld[0] <= w_any;
      r_dat[0] <= w_any & din[w_gnt_idx];
      r_id[0]  <= w_gnt_idx;
      for (int s = 1; s < DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_dat[s] <= r_dat[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end

  assign q         = r_dat[DEPTH-1];
  assign out_valid = r_vld[DEPTH-1];
  assign out_id    = r_id[DEPTH-1];
  assign busy      = |r_vld;

`ifdef SHIFT_PIPE_ARBITER_STATS_EN
  logic [15:0] r_grant_cnt;

  // Stall already forces w_any low, so the count freezes with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_any && (r_grant_cnt != 16'hFFFF)) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// Scoreboard bench for shift_pipe_arbiter: grants are predicted per cycle and issued bits
// are queued with the advance count at which they must appear on q/out_valid/out_id.
module tb_shift_pipe_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 3;
  localparam int IDW   = $clog2(NREQ);

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic            stall;
  logic [NREQ-1:0] gnt;
  logic            q;
  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic            busy;
`ifdef SHIFT_PIPE_ARBITER_STATS_EN
  logic [15:0]     grant_cnt;
`endif

  shift_pipe_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .stall     (stall),
    .gnt       (gnt),
    .q         (q),
    .out_valid (out_valid),
    .out_id    (out_id),
    .busy      (busy)
`ifdef SHIFT_PIPE_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic d;
    int   due;
  } item_t;

  item_t          sb[$];
  int             n_checks = 0;
  int             n_errors = 0;
  int             adv_cnt  = 0;
  bit             fresh    = 1'b1;
  int             m_ptr    = 0;
  int             m_cnt    = 0;
  logic           exp_v    = 1'b0;
  logic           exp_q    = 1'b0;
  logic [IDW-1:0] exp_id   = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r, input int ptr,
                                                output int idx);
    logic [NREQ-1:0] g;
    g   = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (g == '0 && r[j]) begin
        g[j] = 1'b1;
        idx  = j;
      end
    end
    return g;
  endfunction

  // Raise rst between edges, check everything clears at once, hold it across one edge.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
`ifdef SHIFT_PIPE_ARBITER_STATS_EN
    check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    sb.delete();
    m_ptr  = 0;
    m_cnt  = 0;
    exp_v  = 1'b0;
    exp_q  = 1'b0;
    exp_id = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    fresh = 1'b1;
  endtask

  // One cycle: drive at posedge+1, compare at negedge, optionally reset before the next edge.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d, input logic s,
                      input bit rst_mid = 1'b0);
    logic [NREQ-1:0] eg;
    int              gi;
    req   = r;
    din   = d;
    stall = s;
    @(negedge clk);
    if (fresh) begin
      if (sb.size() > 0 && sb[0].due == adv_cnt) begin
        exp_v  = 1'b1;
        exp_q  = sb[0].d;
        exp_id = IDW'(sb[0].id);
      end else begin
        exp_v  = 1'b0;
        exp_q  = 1'b0;
        exp_id = '0;
      end
    end
    check("out_valid", 32'(out_valid), 32'(exp_v));
    check("q", 32'(q), 32'(exp_q));
    check("out_id", 32'(out_id), 32'(exp_id));
    check("busy", 32'(busy), 32'((sb.size() > 0) || exp_v));
    if (fresh && exp_v) void'(sb.pop_front());
    eg = model_gnt(r, m_ptr, gi);
    if (s) eg = '0;
    check("gnt", 32'(gnt), 32'(eg));
    if (rst_mid) begin
      reset_pulse();
    end else begin
      if (eg != '0) begin
        sb.push_back('{id: gi, d: d[gi], due: adv_cnt + DEPTH});
        m_ptr = (gi + 1) % NREQ;
        if (m_cnt < 65535) m_cnt++;
      end
      @(posedge clk);
      fresh = !s;
      if (!s) adv_cnt++;
      #1;
    end
  endtask

  initial begin
    logic [NREQ-1:0] rr;
    logic [NREQ-1:0] dd;
    rst   = 1'b1;
    req   = '0;
    din   = '0;
    stall = 1'b0;
    reset_pulse();

    // Single grant to requester 0, emerges DEPTH cycles later.
    step(4'b0001, 4'b0001, 1'b0);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);

    // All requesting: rotation 0,1,2,3,0,... with alternating data.
    reset_pulse();
    repeat (8) step(4'b1111, 4'b1010, 1'b0);
    repeat (4) step(4'b0000, 4'b0000, 1'b0);

    // Pointer moved to 3, lone requester 2 still found via wrap.
    reset_pulse();
    repeat (5) step(4'b0100, 4'b0100, 1'b0);
    repeat (4) step(4'b0000, 4'b0000, 1'b0);

    // Stall for two cycles delays the output by two cycles and blocks grants.
    reset_pulse();
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);

    // Reset in the third grant cycle drops everything in flight.
    reset_pulse();
    step(4'b1111, 4'b0101, 1'b0);
    step(4'b1111, 4'b0101, 1'b0);
    step(4'b1111, 4'b0101, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 4'b0000, 1'b0);

`ifdef SHIFT_PIPE_ARBITER_STATS_EN
    reset_pulse();
    repeat (5) step(4'b1000, 4'b1000, 1'b0);
    check("grant_cnt_5", 32'(grant_cnt), 32'd5);
`endif

    // Random traffic with occasional stalls.
    repeat (200) begin
      rr = NREQ'($urandom);
      dd = NREQ'($urandom);
      step(rr, dd, $urandom_range(0, 3) == 0);
    end
    repeat (DEPTH + 4) step(4'b0000, 4'b0000, 1'b0);
    check("drain_empty", 32'(sb.size()), 32'd0);
`ifdef SHIFT_PIPE_ARBITER_STATS_EN
    check("grant_cnt_final", 32'(grant_cnt), 32'(m_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
